// File: rtl/nvme_ctrl_state_fsm.sv
// NVMe controller-state sequencer: follows CC.EN/CC.SHN, drives CSTS.RDY/SHST/CFS
// and handshakes init/run/flush with the queue engine under a per-state watchdog.
module nvme_ctrl_state_fsm #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMR_W          = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cc_en,
    input  logic [1:0] cc_shn,
    input  logic       eng_init_ack,
    input  logic       eng_idle,
    output logic       eng_init_req,
    output logic       eng_run,
    output logic       eng_flush_req,
    output logic       csts_rdy,
    output logic [1:0] csts_shst,
    output logic       csts_cfs,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_READY     = 3'd2,
        S_SHDN      = 3'd3,
        S_SHDN_DONE = 3'd4,
        S_RESET     = 3'd5,
        S_FATAL     = 3'd6
    } state_t;

    state_t           r_state;
    logic [TMR_W-1:0] r_tmr;
    logic             r_init_req;
    logic             r_run;
    logic             r_flush_req;
    logic             r_rdy;
    logic [1:0]       r_shst;
    logic             r_cfs;

    state_t           w_nxt;
    logic             w_expire;
    logic             w_shn_req;

    assign w_expire  = (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1));
    assign w_shn_req = (cc_shn == 2'b01) || (cc_shn == 2'b10);

    // cc_en falling is checked first in every state so it beats ack/idle/expiry.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cc_en) w_nxt = S_INIT;
            end
            S_INIT: begin
                if (!cc_en)            w_nxt = S_RESET;
                else if (eng_init_ack) w_nxt = S_READY;
                else if (w_expire)     w_nxt = S_FATAL;
            end
            S_READY: begin
                if (!cc_en)         w_nxt = S_RESET;
                else if (w_shn_req) w_nxt = S_SHDN;
            end
            S_SHDN: begin
                if (!cc_en)        w_nxt = S_RESET;
                else if (eng_idle) w_nxt = S_SHDN_DONE;
                else if (w_expire) w_nxt = S_FATAL;
            end
            S_SHDN_DONE: begin
                if (!cc_en) w_nxt = S_RESET;
            end
            S_RESET: begin
                if (eng_idle) w_nxt = S_IDLE;
            end
            S_FATAL: begin
                if (!cc_en) w_nxt = S_RESET;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            r_init_req  <= 1'b0;
            r_run       <= 1'b0;
            r_flush_req <= 1'b0;
            r_rdy       <= 1'b0;
            r_shst      <= 2'b00;
            r_cfs       <= 1'b0;
        end else begin
            r_state <= w_nxt;

            if (w_nxt != r_state)
                r_tmr <= '0;
            else if (((r_state == S_INIT) || (r_state == S_SHDN)) && (r_tmr != {TMR_W{1'b1}}))
                r_tmr <= r_tmr + 1'b1;

            r_init_req  <= (w_nxt == S_INIT);
            r_run       <= (w_nxt == S_READY);
            r_flush_req <= (w_nxt == S_SHDN) || (w_nxt == S_RESET);
            r_rdy       <= (w_nxt == S_READY) || (w_nxt == S_SHDN) || (w_nxt == S_SHDN_DONE);
            r_shst      <= (w_nxt == S_SHDN)      ? 2'b01 :
                           (w_nxt == S_SHDN_DONE) ? 2'b10 : 2'b00;

            if ((w_nxt == S_FATAL) && (r_state != S_FATAL))
                r_cfs <= 1'b1;
            else if ((w_nxt == S_IDLE) && (r_state != S_IDLE))
                r_cfs <= 1'b0;
        end
    end

    assign eng_init_req  = r_init_req;
    assign eng_run       = r_run;
    assign eng_flush_req = r_flush_req;
    assign csts_rdy      = r_rdy;
    assign csts_shst     = r_shst;
    assign csts_cfs      = r_cfs;
    assign state_o       = r_state;

endmodule

// File: tb/tb_nvme_ctrl_state_fsm.sv
// Bench for nvme_ctrl_state_fsm: directed scenarios with literal expectations, then
// random stimulus, all checked every cycle against a behavioural state model.
module tb_nvme_ctrl_state_fsm;

    localparam int T = 8;
    localparam int ST_IDLE = 0, ST_INIT = 1, ST_READY = 2, ST_SHDN = 3;
    localparam int ST_SDONE = 4, ST_RESET = 5, ST_FATAL = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cc_en = 1'b0;
    logic [1:0] cc_shn = 2'b00;
    logic       eng_init_ack = 1'b0;
    logic       eng_idle = 1'b0;
    logic       eng_init_req, eng_run, eng_flush_req, csts_rdy, csts_cfs;
    logic [1:0] csts_shst;
    logic [2:0] state_o;

    int checks = 0;
    int failures = 0;

    nvme_ctrl_state_fsm #(.TIMEOUT_CYCLES(T), .TMR_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cc_en        (cc_en),
        .cc_shn       (cc_shn),
        .eng_init_ack (eng_init_ack),
        .eng_idle     (eng_idle),
        .eng_init_req (eng_init_req),
        .eng_run      (eng_run),
        .eng_flush_req(eng_flush_req),
        .csts_rdy     (csts_rdy),
        .csts_shst    (csts_shst),
        .csts_cfs     (csts_cfs),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: current state plus number of edges spent in it.
    int m_st  = ST_IDLE;
    int m_age = 0;
    bit m_cfs = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_st = ST_IDLE; m_age = 0; m_cfs = 1'b0;
        end else begin
            int  nx;
            bit  timed_out;
            bit  shn;
            nx        = m_st;
            timed_out = (m_age == T - 1);
            shn       = (cc_shn == 2'd1) || (cc_shn == 2'd2);
            if (m_st == ST_IDLE)       nx = cc_en ? ST_INIT : ST_IDLE;
            else if (m_st == ST_RESET) nx = eng_idle ? ST_IDLE : ST_RESET;
            else if (!cc_en)           nx = ST_RESET;
            else if (m_st == ST_INIT)  nx = eng_init_ack ? ST_READY : (timed_out ? ST_FATAL : ST_INIT);
            else if (m_st == ST_READY) nx = shn ? ST_SHDN : ST_READY;
            else if (m_st == ST_SHDN)  nx = eng_idle ? ST_SDONE : (timed_out ? ST_FATAL : ST_SHDN);
            if (nx == ST_FATAL && m_st != ST_FATAL) m_cfs = 1'b1;
            if (nx == ST_IDLE && m_st != ST_IDLE)   m_cfs = 1'b0;
            m_age = (nx != m_st) ? 0 : m_age + 1;
            m_st  = nx;
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en && reset_n) begin
            chk("m_state", 32'(state_o), 32'(m_st));
            chk("m_rdy", 32'(csts_rdy), 32'(m_st == ST_READY || m_st == ST_SHDN || m_st == ST_SDONE));
            chk("m_shst", 32'(csts_shst), (m_st == ST_SHDN) ? 32'd1 : (m_st == ST_SDONE) ? 32'd2 : 32'd0);
            chk("m_cfs", 32'(csts_cfs), 32'(m_cfs));
            chk("m_init_req", 32'(eng_init_req), 32'(m_st == ST_INIT));
            chk("m_run", 32'(eng_run), 32'(m_st == ST_READY));
            chk("m_flush", 32'(eng_flush_req), 32'(m_st == ST_SHDN || m_st == ST_RESET));
        end
    end

    task automatic nedge(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {25'd0, eng_init_req, eng_run, eng_flush_req, csts_rdy, csts_shst, csts_cfs}, 32'd0);
        chk({nm, "_state"}, 32'(state_o), 32'd0);
    endtask

    initial begin
        #1 chk_all_zero("reset_vals");
        nedge(2);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // Enable then ready.
        nedge(1); cc_en = 1'b1;
        nedge(1); chk("en_state", 32'(state_o), 32'd1); chk("en_init_req", 32'(eng_init_req), 32'd1);
        nedge(2); eng_init_ack = 1'b1;
        nedge(1); eng_init_ack = 1'b0;
        chk("rdy_state", 32'(state_o), 32'd2); chk("rdy_rdy", 32'(csts_rdy), 32'd1);
        chk("rdy_run", 32'(eng_run), 32'd1); chk("rdy_shst", 32'(csts_shst), 32'd0);

        // Normal shutdown.
        cc_shn = 2'b01;
        nedge(1); chk("shdn_shst", 32'(csts_shst), 32'd1); chk("shdn_flush", 32'(eng_flush_req), 32'd1);
        chk("shdn_rdy", 32'(csts_rdy), 32'd1);
        nedge(1); eng_idle = 1'b1;
        nedge(1); eng_idle = 1'b0; cc_shn = 2'b00;
        chk("sdone_shst", 32'(csts_shst), 32'd2);
        nedge(2); chk("sdone_hold", 32'(csts_shst), 32'd2); chk("sdone_state", 32'(state_o), 32'd4);

        // Disable while shutting down with idle on the same edge.
        cc_en = 1'b0;
        nedge(1); eng_idle = 1'b1;
        nedge(1); eng_idle = 1'b0; cc_en = 1'b1;
        nedge(1); eng_init_ack = 1'b1;
        nedge(1); eng_init_ack = 1'b0; cc_shn = 2'b10;
        nedge(1); chk("shdn2_state", 32'(state_o), 32'd3); cc_shn = 2'b00; cc_en = 1'b0; eng_idle = 1'b1;
        nedge(1); chk("dis_state", 32'(state_o), 32'd5);
        nedge(1); eng_idle = 1'b0;
        chk("dis_idle", 32'(state_o), 32'd0); chk("dis_rdy", 32'(csts_rdy), 32'd0);
        chk("dis_shst", 32'(csts_shst), 32'd0);

        // Init timeout.
        cc_en = 1'b1;
        nedge(1); chk("to_init", 32'(state_o), 32'd1);
        for (int i = 1; i < T; i++) begin
            nedge(1); chk("to_wait", 32'(state_o), 32'd1);
        end
        nedge(1); chk("to_fatal", 32'(state_o), 32'd6); chk("to_cfs", 32'(csts_cfs), 32'd1);
        cc_en = 1'b0;
        nedge(1); chk("to_reset", 32'(state_o), 32'd5); chk("to_cfs_rst", 32'(csts_cfs), 32'd1);
        eng_idle = 1'b1;
        nedge(1); eng_idle = 1'b0;
        chk("to_idle", 32'(state_o), 32'd0); chk("to_cfs_clr", 32'(csts_cfs), 32'd0);

        // Ack arriving on the expiry edge.
        cc_en = 1'b1;
        nedge(1);
        nedge(T - 1); eng_init_ack = 1'b1;
        nedge(1); eng_init_ack = 1'b0;
        chk("ackexp_state", 32'(state_o), 32'd2); chk("ackexp_cfs", 32'(csts_cfs), 32'd0);

        // Async reset mid-READY.
        @(posedge clk); #2 reset_n = 1'b0;
        #1 chk_all_zero("async_rst");
        #1 reset_n = 1'b1;
        nedge(1); chk("post_rst_idle", 32'(state_o), 32'd0);
        nedge(1); chk("post_rst_init", 32'(state_o), 32'd1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            nedge(1);
            cc_en        = ($urandom_range(0, 15) != 0);
            cc_shn       = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            eng_init_ack = ($urandom_range(0, 11) == 0);
            eng_idle     = ($urandom_range(0, 9) == 0);
        end
        nedge(2);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
